// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM states, queue entry type and PC alignment helper
package fetch_pkg;
  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 64'd4;
  typedef enum logic [1:0] {LOAD, REQ, WAIT} state_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } entry_t;
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus plus the decode-side valid/ready handshake
interface fetch_if;
  import fetch_pkg::*;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, out_valid, out_ready;
  logic [PC_W-1:0] imem_req_addr, out_pc;
  logic [INSTR_W-1:0] imem_resp_data, out_instr;
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    input imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );
  modport slave (
    input imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sync FIFO of fetched instructions with flush and occupancy count
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  entry_t din,
  output entry_t dout,
  output logic [AW:0] count
);
  localparam int CW = AW + 1;
  entry_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign dout = mem[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= push ? wr + AW'(1) : wr;
      rd <= pop ? rd + AW'(1) : rd;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/FSM fetch stage, one outstanding imem read, queued hand-off to decode.
// Define FETCH_PERF_EN to add saturating perf_fetched/perf_dropped counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic [PC_W-1:0] startpc,
  input  logic redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] currentpc,
  fetch_if.master f
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_t state, state_n;
  logic [PC_W-1:0] pc_q, pc_n, req_pc;
  logic drop, drop_n, accept, resp, push, pop, flush;
  logic [CW-1:0] count;
  entry_t head, din;
  assign flush = redirect && state != LOAD;
  assign resp = state == WAIT && f.imem_resp_valid;
  assign push = resp && !drop && !redirect;
  assign pop = f.out_valid && f.out_ready && !redirect;
  // outstanding is implied by WAIT, so REQ only needs to reserve against queue occupancy
  assign f.imem_req_valid = state == REQ && count < CW'(QDEPTH);
  assign accept = f.imem_req_valid && f.imem_req_ready;
  assign f.imem_req_addr = pc_q;
  assign currentpc = pc_q;
  assign f.out_valid = count != '0;
  assign f.out_instr = f.out_valid ? head.instr : '0;
  assign f.out_pc = f.out_valid ? head.pc : '0;
  assign din = '{instr: f.imem_resp_data, pc: req_pc};
  always_comb begin
    state_n = state == LOAD ? REQ : state == REQ ? (accept ? WAIT : REQ) : state == WAIT ? (f.imem_resp_valid ? REQ : WAIT) : LOAD;
    pc_n = state == LOAD ? word_align(startpc) : redirect ? word_align(redirect_pc) : accept ? pc_q + PC_INC : pc_q;
    drop_n = state == REQ ? accept && redirect : state == WAIT ? !f.imem_resp_valid && (drop || redirect) : 1'b0;
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state <= LOAD;
      pc_q <= '0;
      req_pc <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
      drop <= drop_n;
      req_pc <= accept ? pc_q : req_pc;
    end
  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk(CLK),
    .rst(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din(din),
    .dout(head),
    .count(count)
  );
`ifdef FETCH_PERF_EN
  logic [32:0] fet_sum, drp_sum;
  assign fet_sum = {1'b0, perf_fetched} + 33'(push);
  assign drp_sum = {1'b0, perf_dropped} + 33'(resp && (drop || redirect)) + 33'(flush ? count : '0);
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= fet_sum[32] ? '1 : fet_sum[31:0];
      perf_dropped <= drp_sum[32] ? '1 : drp_sum[31:0];
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with a latency-programmable memory model and start-PC vector table
module tb_instr_fetch_unit;
  import fetch_pkg::*;
  localparam int QD = 2;
  logic CLK = 1'b0, reset = 1'b0, redirect = 1'b0;
  logic [PC_W-1:0] startpc = '0, redirect_pc = '0, currentpc;
  fetch_if f();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif
  instr_fetch_unit #(.QDEPTH(QD)) dut (
    .CLK, .reset, .startpc, .redirect, .redirect_pc, .currentpc,
    .f(f)
`ifdef FETCH_PERF_EN
    , .perf_fetched, .perf_dropped
`endif
  );
  always #5 CLK = ~CLK;

  typedef struct { logic [PC_W-1:0] sp, a0, a1; } vec_t;
  int n_tests = 0, n_fail = 0, lat = 1, wcnt = 0, n_acc = 0, n_push = 0, n_drop = 0;
  entry_t sb[$];
  logic [PC_W-1:0] popped[$];
  logic ld = 1'b0, pending = 1'b0, stale = 1'b0, last_acc = 1'b0;
  logic [PC_W-1:0] exp_pc = '0, paddr = '0, last_addr = '0;

  function automatic logic [INSTR_W-1:0] mk(input logic [PC_W-1:0] a);
    return a[31:0] ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // called at a negedge with inputs set; checks, advances one clock, updates model and memory
  task automatic tick();
    logic acc, pop, rsp, exp_rv;
    exp_rv = !ld && !pending && sb.size() < QD;
    chk("currentpc", currentpc, exp_pc);
    chk("req_addr", f.imem_req_addr, exp_pc);
    chk("req_valid", {63'b0, f.imem_req_valid}, {63'b0, exp_rv});
    chk("out_valid", {63'b0, f.out_valid}, {63'b0, sb.size() != 0});
    if (sb.size() != 0) begin
      chk("out_pc", f.out_pc, sb[0].pc);
      chk("out_instr", {32'b0, f.out_instr}, {32'b0, sb[0].instr});
    end
    acc = exp_rv && f.imem_req_ready;
    pop = sb.size() != 0 && f.out_ready && !redirect;
    rsp = pending && f.imem_resp_valid;
    last_acc = acc;
    last_addr = f.imem_req_addr;
    if (pop) popped.push_back(f.out_pc);
    @(posedge CLK);
    if (ld) begin
      exp_pc = word_align(startpc);
      ld = 1'b0;
    end else begin
      if (redirect) begin
        n_drop += sb.size();
        sb.delete();
      end else if (pop) void'(sb.pop_front());
      if (rsp) begin
        if (stale || redirect) n_drop++;
        else begin
          sb.push_back('{instr: mk(paddr), pc: paddr});
          n_push++;
        end
        pending = 1'b0;
      end
      if (redirect && pending) stale = 1'b1;
      if (acc) begin
        pending = 1'b1;
        paddr = exp_pc;
        stale = redirect;
        wcnt = lat - 1;
        n_acc++;
        exp_pc = exp_pc + 64'd4;
      end
      if (redirect) exp_pc = word_align(redirect_pc);
    end
    @(negedge CLK);
    if (pending && !acc && wcnt != 0) wcnt--;
    f.imem_resp_valid = pending && wcnt == 0;
    f.imem_resp_data = mk(paddr);
  endtask

  task automatic do_reset(input logic [PC_W-1:0] sp);
    reset = 1'b1;
    redirect = 1'b0;
    #1;
    chk("rst_req_valid", {63'b0, f.imem_req_valid}, 64'd0);
    chk("rst_req_addr", f.imem_req_addr, 64'd0);
    chk("rst_out_valid", {63'b0, f.out_valid}, 64'd0);
    chk("rst_out_instr", {32'b0, f.out_instr}, 64'd0);
    chk("rst_out_pc", f.out_pc, 64'd0);
    chk("rst_currentpc", currentpc, 64'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", {32'b0, perf_fetched}, 64'd0);
    chk("rst_perf_dropped", {32'b0, perf_dropped}, 64'd0);
`endif
    sb.delete();
    popped.delete();
    pending = 1'b0;
    stale = 1'b0;
    exp_pc = '0;
    f.imem_resp_valid = 1'b0;
    n_acc = 0;
    n_push = 0;
    n_drop = 0;
    startpc = sp;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    ld = 1'b1;
  endtask

  task automatic next_acc(output logic [PC_W-1:0] a);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!last_acc && k < 50);
    chk("acc_timeout", {63'b0, last_acc}, 64'd1);
    a = last_addr;
  endtask

  task automatic perf_chk();
`ifdef FETCH_PERF_EN
    chk("perf_fetched", {32'b0, perf_fetched}, 64'(n_push));
    chk("perf_dropped", {32'b0, perf_dropped}, 64'(n_drop));
`endif
  endtask

  function automatic logic [PC_W-1:0] pop_at(input int i);
    return popped.size() > i ? popped[i] : '1;
  endfunction

  initial begin
    vec_t tv[4];
    logic [PC_W-1:0] a;
    int k, found;
    tv[0] = '{64'h30, 64'h30, 64'h34};
    tv[1] = '{64'h57, 64'h54, 64'h58};
    tv[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    tv[3] = '{64'h0, 64'h0, 64'h4};
    f.imem_req_ready = 1'b1;
    f.imem_resp_valid = 1'b0;
    f.imem_resp_data = '0;
    f.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_reset(tv[i].sp);
      next_acc(a);
      chk($sformatf("tbl%0d_a0", i), a, tv[i].a0);
      next_acc(a);
      chk($sformatf("tbl%0d_a1", i), a, tv[i].a1);
      perf_chk();
    end
    lat = 1;
    do_reset(64'h30);
    repeat (14) tick();
    chk("seq_pc0", pop_at(0), 64'h30);
    chk("seq_pc1", pop_at(1), 64'h34);
    chk("seq_pc2", pop_at(2), 64'h38);
    do_reset(64'h30);
    f.out_ready = 1'b0;
    repeat (12) tick();
    chk("bp_reqs", 64'(n_acc), 64'd2);
    chk("bp_req_valid", {63'b0, f.imem_req_valid}, 64'd0);
    f.out_ready = 1'b1;
    next_acc(a);
    chk("bp_resume", a, 64'h38);
    lat = 2;
    do_reset(64'h30);
    k = 0;
    while (!(pending && paddr == 64'h34 && !f.imem_resp_valid) && k < 50) begin tick(); k++; end
    chk("reach_wait34", {63'b0, k < 50}, 64'd1);
    popped.delete();
    redirect = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect = 1'b0;
    repeat (12) tick();
    found = 0;
    foreach (popped[i]) if (popped[i] == 64'h34) found++;
    chk("rd1_first_pc", pop_at(0), 64'h100);
    chk("rd1_no_stale", 64'(found), 64'd0);
    perf_chk();
    lat = 1;
    do_reset(64'h30);
    k = 0;
    while (!(pending && paddr == 64'h40 && f.imem_resp_valid) && k < 50) begin tick(); k++; end
    chk("reach_resp40", {63'b0, k < 50}, 64'd1);
    redirect = 1'b1;
    redirect_pc = 64'h203;
    tick();
    redirect = 1'b0;
    chk("rd2_out_valid", {63'b0, f.out_valid}, 64'd0);
    next_acc(a);
    chk("rd2_next_addr", a, 64'h200);
    repeat (4) tick();
    perf_chk();
    lat = 3;
    do_reset(64'h30);
    k = 0;
    while (!(pending && !f.imem_resp_valid) && k < 50) begin tick(); k++; end
    chk("reach_wait_rst", {63'b0, k < 50}, 64'd1);
    lat = 1;
    do_reset(64'h54);
    next_acc(a);
    chk("rst_mid_first", a, 64'h54);
    repeat (6) tick();
    perf_chk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
